turbo_ilv_seq_ctrl: RTL and testbench

//  Frame sequencer for the turbo encoder front end. Accepts message bytes on a valid/ready port.

---
 rtl/turbo_pkg.sv | 23 ++
 rtl/turbo_ilv_seq_ctrl_if.sv | 36 +++
 rtl/turbo_bit_serializer.sv | 80 ++++++++
 rtl/turbo_ilv_seq_ctrl.sv | 176 +++++++++++++++++
 tb/tb_turbo_ilv_seq_ctrl.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/turbo_pkg.sv
// rtl/turbo_pkg.sv - shared types and default constants for the turbo frame sequencer
//   Provides the sequencer state encoding, the byte width, and default values
//   for the frame, tail, interleaver-latency and watchdog parameters.
package turbo_pkg;

  localparam int TURBO_BYTE_W    = 8;
  localparam int DEF_FRAME_BYTES = 16;
  localparam int DEF_TAIL_BITS   = 3;
  localparam int DEF_ILV_LAT     = 3;
  localparam int DEF_TMO_CYC     = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SER  = 2'd2,
    TAIL = 2'd3
  } seq_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/turbo_ilv_seq_ctrl_if.sv
// rtl/turbo_ilv_seq_ctrl_if.sv - bus bundle between the sequencer and its neighbours
//   Message input (in_*), interleaver port (ilv_*), encoder-branch output (out_*)
//   and frame status (frame_start, frame_done, err_tmo).
//   slave  : sequencer side
//   master : message source / interleaver / encoder side
interface turbo_ilv_seq_ctrl_if;
  import turbo_pkg::*;

  logic [TURBO_BYTE_W-1:0] in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic [TURBO_BYTE_W-1:0] ilv_data;
  logic                    ilv_enable;
  logic [TURBO_BYTE_W-1:0] ilv_seq;
  logic                    out_sys;
  logic                    out_ilv;
  logic                    out_tail;
  logic                    out_valid;
  logic                    out_ready;
  logic                    frame_start;
  logic                    frame_done;
  logic                    err_tmo;

  modport slave (
    input  in_data, in_valid, ilv_enable, ilv_seq, out_ready,
    output in_ready, ilv_data, out_sys, out_ilv, out_tail, out_valid,
           frame_start, frame_done, err_tmo
  );

  modport master (
    output in_data, in_valid, ilv_enable, ilv_seq, out_ready,
    input  in_ready, ilv_data, out_sys, out_ilv, out_tail, out_valid,
           frame_start, frame_done, err_tmo
  );

endinterface

// File: rtl/turbo_bit_serializer.sv
// rtl/turbo_bit_serializer.sv - bit-pair serializer with valid/ready output hold
//   clk, rst_n        clock, asynchronous active-low reset
//   load_i            load sys/ilv bytes, start at bit 0 (out_valid=1)
//   tail_i            start tail beats (out_valid=1, out_tail=1, bits 0)
//   stop_i            drop out_valid and clear the bit registers
//   sys_byte_i        natural byte
//   ilv_byte_i        interleaved byte
//   out_ready_i       consumer ready
//   idx_o             index of the bit pair currently presented
//   beat_o            current bit pair accepted this cycle
//   out_sys_o/out_ilv_o/out_valid_o/out_tail_o  registered encoder outputs
module turbo_bit_serializer
  import turbo_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load_i,
  input  logic                    tail_i,
  input  logic                    stop_i,
  input  logic [TURBO_BYTE_W-1:0] sys_byte_i,
  input  logic [TURBO_BYTE_W-1:0] ilv_byte_i,
  input  logic                    out_ready_i,
  output logic [2:0]              idx_o,
  output logic                    beat_o,
  output logic                    out_sys_o,
  output logic                    out_ilv_o,
  output logic                    out_valid_o,
  output logic                    out_tail_o
);

  logic [TURBO_BYTE_W-1:0] sys_sh_q;
  logic [TURBO_BYTE_W-1:0] ilv_sh_q;
  logic [2:0]              idx_q;
  logic                    valid_q;
  logic                    tail_q;

  assign beat_o = valid_q & out_ready_i;

  // Controller commands win over the local shift; the controller always issues
  // tail_i or stop_i on the bit-7 beat, so the shift never runs past bit 7.
  // Nothing moves while valid_q && !out_ready_i, which holds the outputs stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sys_sh_q <= '0;
      ilv_sh_q <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      tail_q   <= 1'b0;
    end else if (load_i) begin
      sys_sh_q <= sys_byte_i;
      ilv_sh_q <= ilv_byte_i;
      idx_q    <= '0;
      valid_q  <= 1'b1;
      tail_q   <= 1'b0;
    end else if (tail_i) begin
      sys_sh_q <= '0;
      ilv_sh_q <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b1;
      tail_q   <= 1'b1;
    end else if (stop_i) begin
      sys_sh_q <= '0;
      ilv_sh_q <= '0;
      idx_q    <= '0;
      valid_q  <= 1'b0;
      tail_q   <= 1'b0;
    end else if (beat_o && !tail_q) begin
      sys_sh_q <= {1'b0, sys_sh_q[TURBO_BYTE_W-1:1]};
      ilv_sh_q <= {1'b0, ilv_sh_q[TURBO_BYTE_W-1:1]};
      idx_q    <= idx_q + 3'd1;
    end
  end

  assign idx_o       = idx_q;
  assign out_sys_o   = sys_sh_q[0];
  assign out_ilv_o   = ilv_sh_q[0];
  assign out_valid_o = valid_q;
  assign out_tail_o  = tail_q;

endmodule

// File: rtl/turbo_ilv_seq_ctrl.sv
// rtl/turbo_ilv_seq_ctrl.sv - turbo encoder front-end frame sequencer
//   Accepts message bytes, passes each through the external block interleaver,
//   and serialises natural/interleaved bit pairs LSB first to the two RSC
//   branches, closing every frame with TAIL_BITS termination beats.
//   clk, rst_n   clock, asynchronous active-low reset
//   bus (slave)  in_data/in_valid/in_ready   message bytes
//                ilv_data/ilv_enable/ilv_seq  interleaver port
//                out_sys/out_ilv/out_tail/out_valid/out_ready  encoder bits
//                frame_start/frame_done/err_tmo  frame status
//   Optional: TURBO_SEQ_TIMEOUT_EN adds a TMO_CYC watchdog on WAIT and drives err_tmo.
module turbo_ilv_seq_ctrl
  import turbo_pkg::*;
#(
  parameter int FRAME_BYTES = DEF_FRAME_BYTES,
  parameter int ILV_LAT     = DEF_ILV_LAT,
  parameter int TAIL_BITS   = DEF_TAIL_BITS,
  parameter int TMO_CYC     = DEF_TMO_CYC
) (
  input logic                  clk,
  input logic                  rst_n,
  turbo_ilv_seq_ctrl_if.slave  bus
);

  localparam int BCW = $clog2(FRAME_BYTES + 1);
  localparam int TCW = (TAIL_BITS > 0) ? $clog2(TAIL_BITS + 1) : 1;
  localparam int WCW = $clog2(max2(ILV_LAT, TMO_CYC) + 1);
  localparam bit HAS_TAIL = (TAIL_BITS > 0);

  localparam logic [BCW-1:0] LAST_BYTE = BCW'(FRAME_BYTES - 1);
  localparam logic [TCW-1:0] TAIL_LAST = TCW'((TAIL_BITS > 0) ? TAIL_BITS - 1 : 0);
  localparam logic [WCW-1:0] WAIT_MIN  = WCW'(ILV_LAT - 1);
  localparam logic [WCW-1:0] WAIT_MAX  = {WCW{1'b1}};
`ifdef TURBO_SEQ_TIMEOUT_EN
  localparam logic [WCW-1:0] TMO_LAST  = WCW'(TMO_CYC - 1);
`endif

  seq_state_t              state_q;
  logic [BCW-1:0]          byte_cnt_q;
  logic [WCW-1:0]          wait_cnt_q;
  logic [TCW-1:0]          tail_cnt_q;
  logic [TURBO_BYTE_W-1:0] ilv_data_q;
  logic                    in_ready_q;
  logic                    frame_start_q;
  logic                    frame_done_q;
`ifdef TURBO_SEQ_TIMEOUT_EN
  logic                    err_tmo_q;
`endif

  logic       ser_load, ser_tail, ser_stop;
  logic       beat, ser_last, last_byte, tail_last, wait_ok;
  logic [2:0] ser_idx;
  logic       ser_sys, ser_ilv, ser_valid, ser_tail_flag;

  assign ser_last  = (ser_idx == 3'd7);
  assign last_byte = (byte_cnt_q == LAST_BYTE);
  assign tail_last = (tail_cnt_q == TAIL_LAST);
  // wait_cnt_q is 0 in the first WAIT cycle, so the earliest sample edge is the
  // ILV_LAT-th edge after ilv_data was updated. ilv_enable alone is not trusted:
  // the interleaver leaves it high across equal consecutive bytes.
  assign wait_ok   = (wait_cnt_q >= WAIT_MIN);

  // A last-bit beat on the last byte goes to TAIL directly, never via IDLE.
  assign ser_load = (state_q == WAIT) && wait_ok && bus.ilv_enable;
  assign ser_tail = (state_q == SER) && beat && ser_last && last_byte && HAS_TAIL;
  assign ser_stop = ((state_q == SER) && beat && ser_last && !(last_byte && HAS_TAIL)) ||
                    ((state_q == TAIL) && beat && tail_last);

  turbo_bit_serializer u_ser (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (ser_load),
    .tail_i      (ser_tail),
    .stop_i      (ser_stop),
    .sys_byte_i  (ilv_data_q),
    .ilv_byte_i  (bus.ilv_seq),
    .out_ready_i (bus.out_ready),
    .idx_o       (ser_idx),
    .beat_o      (beat),
    .out_sys_o   (ser_sys),
    .out_ilv_o   (ser_ilv),
    .out_valid_o (ser_valid),
    .out_tail_o  (ser_tail_flag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      byte_cnt_q    <= '0;
      wait_cnt_q    <= '0;
      tail_cnt_q    <= '0;
      ilv_data_q    <= '0;
      in_ready_q    <= 1'b0;
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
`ifdef TURBO_SEQ_TIMEOUT_EN
      err_tmo_q     <= 1'b0;
`endif
    end else begin
      frame_start_q <= 1'b0;
      frame_done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          in_ready_q <= 1'b1;
          if (bus.in_valid && in_ready_q) begin
            ilv_data_q    <= bus.in_data;
            in_ready_q    <= 1'b0;
            wait_cnt_q    <= '0;
            frame_start_q <= (byte_cnt_q == '0);
            state_q       <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt_q != WAIT_MAX) wait_cnt_q <= wait_cnt_q + 1'b1;
          if (ser_load) begin
            state_q <= SER;
`ifdef TURBO_SEQ_TIMEOUT_EN
          end else if (wait_cnt_q == TMO_LAST) begin
            // Abandon the whole frame; the next byte starts a fresh one.
            err_tmo_q  <= 1'b1;
            byte_cnt_q <= '0;
            in_ready_q <= 1'b1;
            state_q    <= IDLE;
`endif
          end
        end
        SER: begin
          if (beat && ser_last) begin
            if (last_byte && HAS_TAIL) begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
              tail_cnt_q <= '0;
              state_q    <= TAIL;
            end else if (last_byte) begin
              byte_cnt_q   <= '0;
              frame_done_q <= 1'b1;
              in_ready_q   <= 1'b1;
              state_q      <= IDLE;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
              in_ready_q <= 1'b1;
              state_q    <= IDLE;
            end
          end
        end
        TAIL: begin
          if (beat) begin
            if (tail_last) begin
              tail_cnt_q   <= '0;
              byte_cnt_q   <= '0;
              frame_done_q <= 1'b1;
              in_ready_q   <= 1'b1;
              state_q      <= IDLE;
            end else begin
              tail_cnt_q <= tail_cnt_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.ilv_data    = ilv_data_q;
  assign bus.out_sys     = ser_sys;
  assign bus.out_ilv     = ser_ilv;
  assign bus.out_valid   = ser_valid;
  assign bus.out_tail    = ser_tail_flag;
  assign bus.frame_start = frame_start_q;
  assign bus.frame_done  = frame_done_q;
`ifdef TURBO_SEQ_TIMEOUT_EN
  assign bus.err_tmo     = err_tmo_q;
`else
  assign bus.err_tmo     = 1'b0;
`endif

endmodule

// File: tb/tb_turbo_ilv_seq_ctrl.sv
// tb/tb_turbo_ilv_seq_ctrl.sv - directed bench for turbo_ilv_seq_ctrl
//   dut_a: FRAME_BYTES=2, ILV_LAT=3, TAIL_BITS=3; dut_b: FRAME_BYTES=1, TAIL_BITS=0.
//   The interleaver stand-in is a rotate-left-by-3 with two cycles of latency.
module tb_turbo_ilv_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  turbo_ilv_seq_ctrl_if bus_a ();
  turbo_ilv_seq_ctrl_if bus_b ();

  turbo_ilv_seq_ctrl #(.FRAME_BYTES(2), .ILV_LAT(3), .TAIL_BITS(3), .TMO_CYC(15)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a));
  turbo_ilv_seq_ctrl #(.FRAME_BYTES(1), .ILV_LAT(3), .TAIL_BITS(0), .TMO_CYC(15)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rotl3(input logic [7:0] b);
    return {b[4:0], b[7:5]};
  endfunction

  // interleaver stand-in: permuted byte appears two edges after ilv_data changes
  logic [7:0] pa1 = '0, pa2 = '0, pb1 = '0, pb2 = '0;
  always @(posedge clk) begin
    pa1 <= rotl3(bus_a.ilv_data); pa2 <= pa1;
    pb1 <= rotl3(bus_b.ilv_data); pb2 <= pb1;
  end
  assign bus_a.ilv_seq = pa2;
  assign bus_b.ilv_seq = pb2;

  // monitors
  int  fs_a = 0, fs_b = 0, fd_tot_a = 0;
  time acc_t_a = 0;
  int  lat_q_a[$];
  logic pv_a = 1'b0;
  always @(posedge clk) if (bus_a.in_valid && bus_a.in_ready) acc_t_a = $time;
  always @(negedge clk) begin
    if (bus_a.frame_start) fs_a++;
    if (bus_b.frame_start) fs_b++;
    if (bus_a.frame_done) fd_tot_a++;
    if (bus_a.out_valid && !pv_a && !bus_a.out_tail)
      lat_q_a.push_back(int'((($time - 5) - acc_t_a) / 10));
    pv_a = bus_a.out_valid;
  end

  function automatic logic [15:0] snap_a();
    return {bus_a.out_valid, bus_a.out_tail, bus_a.out_sys, bus_a.out_ilv, bus_a.in_ready,
            bus_a.frame_start, bus_a.frame_done, bus_a.err_tmo, bus_a.ilv_data};
  endfunction
  function automatic logic [15:0] snap_b();
    return {bus_b.out_valid, bus_b.out_tail, bus_b.out_sys, bus_b.out_ilv, bus_b.in_ready,
            bus_b.frame_start, bus_b.frame_done, bus_b.err_tmo, bus_b.ilv_data};
  endfunction

  task automatic send_a(input logic [7:0] b);
    int n = 0;
    bus_a.in_data  = b;
    bus_a.in_valid = 1'b1;
    while (!bus_a.in_ready && n < 100) begin @(negedge clk); n++; end
    chk("send_a_ready", bus_a.in_ready, 1);
    @(posedge clk); #1;
    bus_a.in_valid = 1'b0;
  endtask

  logic [7:0] sys_by[4], ilv_by[4];
  int nb, tail_n, tail_nz, fd_beat, fd_n;

  task automatic collect_a(input int nbeats, input bit stall);
    int cyc = 0, di = 0;
    logic [3:0] pat = 4'b1001;
    logic [3:0] held = '0;
    bit stalled = 1'b0;
    nb = 0; tail_n = 0; tail_nz = 0; fd_beat = -1; fd_n = 0;
    for (int k = 0; k < 4; k++) begin sys_by[k] = '0; ilv_by[k] = '0; end
    while (nb < nbeats && cyc < 3000) begin
      @(negedge clk); cyc++;
      bus_a.out_ready = stall ? pat[cyc % 4] : 1'b1;
      if (stalled)
        chk("hold", {bus_a.out_valid, bus_a.out_tail, bus_a.out_sys, bus_a.out_ilv}, held);
      if (bus_a.frame_done) begin fd_n++; fd_beat = nb; end
      stalled = bus_a.out_valid && !bus_a.out_ready;
      held = {bus_a.out_valid, bus_a.out_tail, bus_a.out_sys, bus_a.out_ilv};
      if (bus_a.out_valid && bus_a.out_ready) begin
        if (bus_a.out_tail) begin
          tail_n++;
          if (bus_a.out_sys || bus_a.out_ilv) tail_nz++;
        end else if (di < 32) begin
          sys_by[di/8][di%8] = bus_a.out_sys;
          ilv_by[di/8][di%8] = bus_a.out_ilv;
          di++;
        end
        nb++;
      end
    end
    @(negedge clk);
    bus_a.out_ready = 1'b1;
    if (bus_a.frame_done) begin fd_n++; fd_beat = nb; end
    chk("beat_cnt", nb, nbeats);
  endtask

  task automatic check_frame(input string p, input logic [7:0] s0, s1, i0, i1);
    chk({p, "_sys0"}, sys_by[0], s0);
    chk({p, "_sys1"}, sys_by[1], s1);
    chk({p, "_ilv0"}, ilv_by[0], i0);
    chk({p, "_ilv1"}, ilv_by[1], i1);
    chk({p, "_tail_n"}, tail_n, 3);
    chk({p, "_tail_zero"}, tail_nz, 0);
    chk({p, "_fd_beat"}, fd_beat, 19);
    chk({p, "_fd_n"}, fd_n, 1);
  endtask

  task automatic check_lat(input string p, input int n);
    chk({p, "_lat_n"}, lat_q_a.size(), n);
    foreach (lat_q_a[i]) chk({p, "_lat"}, lat_q_a[i], 3);
    lat_q_a.delete();
  endtask

  task automatic run_b(input logic [7:0] b, input logic [7:0] exp_ilv);
    int cyc = 0, n = 0, fd_at = -1, fs0;
    logic [7:0] s = '0, v = '0;
    bit tl = 1'b0;
    fs0 = fs_b;
    bus_b.in_data = b; bus_b.in_valid = 1'b1;
    while (!bus_b.in_ready && cyc < 100) begin @(negedge clk); cyc++; end
    chk("b_ready", bus_b.in_ready, 1);
    @(posedge clk); #1;
    bus_b.in_valid = 1'b0;
    cyc = 0;
    while (n < 8 && cyc < 200) begin
      @(negedge clk); cyc++;
      if (bus_b.frame_done) fd_at = n;
      if (bus_b.out_tail) tl = 1'b1;
      if (bus_b.out_valid) begin s[n] = bus_b.out_sys; v[n] = bus_b.out_ilv; n++; end
    end
    @(negedge clk);
    if (bus_b.frame_done) fd_at = n;
    if (bus_b.out_tail) tl = 1'b1;
    chk("b_sys", s, b);
    chk("b_ilv", v, exp_ilv);
    chk("b_fd_beat", fd_at, 8);
    chk("b_no_tail", tl, 0);
    chk("b_fs", fs_b - fs0, 1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int fs0, fd0;
    bus_a.in_data = '0; bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b0; bus_a.ilv_enable = 1'b1;
    bus_b.in_data = '0; bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b1; bus_b.ilv_enable = 1'b1;

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_a", snap_a(), 16'h0);
    chk("rst_b", snap_b(), 16'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", bus_a.in_ready, 1);

    // 1: A5, 3C, no backpressure
    lat_q_a.delete();
    fs0 = fs_a;
    fork
      begin send_a(8'hA5); send_a(8'h3C); end
      collect_a(19, 1'b0);
    join
    check_frame("t1", 8'hA5, 8'h3C, 8'h2D, 8'hE1);
    check_lat("t1", 2);
    chk("t1_fs", fs_a - fs0, 1);

    // 2: equal bytes with ilv_enable held high
    fork
      begin send_a(8'h55); send_a(8'h55); end
      collect_a(19, 1'b0);
    join
    check_frame("t2", 8'h55, 8'h55, 8'hAA, 8'hAA);
    check_lat("t2", 2);

    // 3: backpressure pattern 1,0,0,1
    fork
      begin send_a(8'h96); send_a(8'h0F); end
      collect_a(19, 1'b1);
    join
    check_frame("t3", 8'h96, 8'h0F, 8'hB4, 8'h78);
    check_lat("t3", 2);

`ifdef TURBO_SEQ_TIMEOUT_EN
    // 5: watchdog expiry
    bus_a.ilv_enable = 1'b0;
    fd0 = fd_tot_a;
    send_a(8'h81);
    repeat (15) @(negedge clk);
    chk("t5_pre_tmo", bus_a.err_tmo, 0);
    @(negedge clk);
    chk("t5_tmo", bus_a.err_tmo, 1);
    chk("t5_ready", bus_a.in_ready, 1);
    chk("t5_no_valid", bus_a.out_valid, 0);
    chk("t5_no_fd", fd_tot_a - fd0, 0);
    bus_a.ilv_enable = 1'b1;
`else
    // WAIT holds indefinitely without ilv_enable
    bus_a.ilv_enable = 1'b0;
    send_a(8'h81);
    repeat (40) @(negedge clk);
    chk("nt_ready", bus_a.in_ready, 0);
    chk("nt_valid", bus_a.out_valid, 0);
    chk("nt_err", bus_a.err_tmo, 0);
    bus_a.ilv_enable = 1'b1;
    fork
      send_a(8'h7E);
      collect_a(19, 1'b0);
    join
    check_frame("nt", 8'h81, 8'h7E, 8'h0C, 8'hF3);
`endif
    lat_q_a.delete();

    // 4: reset at bit 4 of byte 1
    fork
      begin send_a(8'h12); send_a(8'h34); end
      collect_a(12, 1'b0);
    join
    chk("t4_pre_valid", bus_a.out_valid, 1);
    chk("t4_pre_data", bus_a.ilv_data, 8'h34);
    fd0 = fd_tot_a;
    rst_n = 1'b0;
    #1;
    chk("t4_rst_outs", snap_a(), 16'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("t4_no_fd", fd_tot_a - fd0, 0);
    fs0 = fs_a;
    fork
      begin send_a(8'h5A); send_a(8'hC3); end
      collect_a(19, 1'b0);
    join
    chk("t4_fs", fs_a - fs0, 1);
    check_frame("t4", 8'h5A, 8'hC3, 8'hD2, 8'h1E);

    // 6: single-byte frames, no tail
    run_b(8'hC3, 8'h1E);
    run_b(8'h5A, 8'hD2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
